// File: rtl/mod_pack_ctrl_pkg.sv
// Shared types and constants for the modulator packing-stage sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mod_pack_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int ARM_CYCLES_DEF = 4;
    localparam int LEN_W_DEF      = 16;
    localparam int CH_NUM         = 2;

endpackage

// File: rtl/mod_frame_cnt.sv
// Frame counter for a burst: clearable, saturating, with a "next frame is the last" compare.
// Latency: count updates on the edge after inc; term is combinational from the registers.
// Backpressure: none; inc is honoured every cycle it is high.
module mod_frame_cnt
    import mod_pack_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    input  logic [LEN_W-1:0] len_i,
    output logic [LEN_W-1:0] cnt_o,
    output logic             term_o
);

    logic [LEN_W-1:0] len_q;

    // Latch burst length on start; count frames, clear wins, hold at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_o <= '0;
            len_q <= '0;
        end else begin
            if (load_i) begin
                len_q <= len_i;
            end
            if (clr_i) begin
                cnt_o <= '0;
            end else if (inc_i && (cnt_o != '1)) begin
                cnt_o <= cnt_o + 1'b1;
            end
        end
    end

    // Length 0 means continuous: never terminal.
    assign term_o = (len_q != '0) && (cnt_o == (len_q - 1'b1));

endmodule

// File: rtl/mod_pack_ctrl.sv
// Sequencer for the 2x32->128 packer: phase select, frame-aligned lane enables, ARM/RUN/DRAIN bursts.
// Latency: start -> first RUN phase-0 cycle is 1 + ARM_CYCLES clocks; all outputs registered.
// Backpressure: none; start ignored outside IDLE, stop ignored in DRAIN. MOD_CTRL_AUTORESTART_EN re-arms after length-ended bursts.
module mod_pack_ctrl
    import mod_pack_ctrl_pkg::*;
#(
    parameter int ARM_CYCLES = ARM_CYCLES_DEF,
    parameter int LEN_W      = LEN_W_DEF
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [1:0]       ch_en_req_i,
    input  logic [LEN_W-1:0] burst_len_i,
    output logic             phase_o,
    output logic             ch0_en_o,
    output logic             ch1_en_o,
    output logic             frame_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] frame_cnt_o
);

    localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES - 1);

    state_t            state;
    logic [7:0]        arm_cnt;
    logic              stop_pend;
    logic [CH_NUM-1:0] ch_en;
    logic              term;
    logic              start_acc;
    logic              run_exit;
    logic              rearm;

    assign start_acc = (state == S_IDLE) && start_i && !stop_i;
    // Exit is decided on the phase-1 tick so the frame in flight always completes.
    assign run_exit  = (state == S_RUN) && phase_o && (stop_pend || stop_i || term);

`ifdef MOD_CTRL_AUTORESTART_EN
    logic stop_drain;

    // Remember why DRAIN was entered: only a length-ended burst re-arms.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stop_drain <= 1'b0;
        end else if (run_exit) begin
            stop_drain <= stop_pend || stop_i;
        end
    end

    assign rearm = (state == S_DRAIN) && phase_o && !stop_drain;
`else
    assign rearm = 1'b0;
`endif

    // Frame counter is cleared on every entry to ARM so it reports the current burst.
    mod_frame_cnt #(
        .LEN_W (LEN_W)
    ) u_frame_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (start_acc || rearm),
        .load_i  (start_acc),
        .inc_i   ((state == S_RUN) && phase_o),
        .len_i   (burst_len_i),
        .cnt_o   (frame_cnt_o),
        .term_o  (term)
    );

    // Burst FSM with registered phase, enables, frame_valid and done.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= S_IDLE;
            arm_cnt       <= '0;
            stop_pend     <= 1'b0;
            phase_o       <= 1'b0;
            ch_en         <= '0;
            frame_valid_o <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            frame_valid_o <= 1'b0;
            done_o        <= 1'b0;
            case (state)
                S_IDLE: begin
                    phase_o   <= 1'b0;
                    ch_en     <= '0;
                    stop_pend <= 1'b0;
                    if (start_acc) begin
                        state   <= S_ARM;
                        arm_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (stop_i) begin
                        state <= S_IDLE;
                    end else if (arm_cnt == ARM_LAST) begin
                        state   <= S_RUN;
                        phase_o <= 1'b0;
                        ch_en   <= ch_en_req_i;
                    end else begin
                        arm_cnt <= arm_cnt + 8'd1;
                    end
                end
                S_RUN: begin
                    if (!phase_o) begin
                        phase_o <= 1'b1;
                        if (stop_i) begin
                            stop_pend <= 1'b1;
                        end
                    end else begin
                        frame_valid_o <= 1'b1;
                        phase_o       <= 1'b0;
                        if (run_exit) begin
                            state     <= S_DRAIN;
                            ch_en     <= '0;
                            stop_pend <= 1'b0;
                        end else begin
                            ch_en <= ch_en_req_i;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!phase_o) begin
                        phase_o <= 1'b1;
                    end else begin
                        phase_o <= 1'b0;
                        done_o  <= 1'b1;
                        if (rearm) begin
                            state   <= S_ARM;
                            arm_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = (state != S_IDLE);
    assign ch0_en_o = ch_en[0];
    assign ch1_en_o = ch_en[1];

endmodule
